// File: rtl/activation_stream.sv
// Two-stage stallable activation pipeline between FWFT FIFOs: per-lane activation, then signed narrowing with saturation.
// Define ACTIVATION_STREAM_STATS_EN to add the word/saturation/negative-input counter ports.
module activation_stream #(
  parameter int DWIDTH_IN  = 16,
  parameter int DWIDTH_OUT = 8,
  parameter int LANES      = 2,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_MAX   = 96
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  mode,
  output logic                        fifo_in_rd_en,
  input  logic [LANES*DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                        fifo_in_empty,
  output logic                        fifo_out_wr_en,
  output logic [LANES*DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                        fifo_out_full,
  output logic                        busy
`ifdef ACTIVATION_STREAM_STATS_EN
  ,
  output logic [31:0]                 word_count,
  output logic [31:0]                 sat_count,
  output logic [31:0]                 neg_count
`endif
);

  localparam int WI = DWIDTH_IN + 1;
  localparam logic signed [WI-1:0] CLIP_W  = WI'(CLIP_MAX);
  localparam logic signed [WI-1:0] OUT_MAX = {{(WI-DWIDTH_OUT+1){1'b0}}, {(DWIDTH_OUT-1){1'b1}}};
  localparam logic signed [WI-1:0] OUT_MIN = {{(WI-DWIDTH_OUT+1){1'b1}}, {(DWIDTH_OUT-1){1'b0}}};

  function automatic logic signed [WI-1:0] act_f(input logic signed [DWIDTH_IN-1:0] x,
                                                 input logic [1:0] m);
    logic signed [WI-1:0] xe;
    logic signed [WI-1:0] r;
    xe = {x[DWIDTH_IN-1], x};
    case (m)
      2'b00:   r = xe;
      2'b01:   r = x[DWIDTH_IN-1] ? '0 : xe;
      2'b10:   r = x[DWIDTH_IN-1] ? (xe >>> LEAK_SHIFT) : xe;
      2'b11:   r = x[DWIDTH_IN-1] ? '0 : ((xe > CLIP_W) ? CLIP_W : xe);
      default: r = xe;
    endcase
    return r;
  endfunction

  function automatic logic [DWIDTH_OUT-1:0] sat_val(input logic signed [WI-1:0] v);
    logic [DWIDTH_OUT-1:0] r;
    if (v > OUT_MAX) begin
      r = {1'b0, {(DWIDTH_OUT-1){1'b1}}};
    end else if (v < OUT_MIN) begin
      r = {1'b1, {(DWIDTH_OUT-1){1'b0}}};
    end else begin
      r = v[DWIDTH_OUT-1:0];
    end
    return r;
  endfunction

  logic                       s1_valid_r;
  logic                       s2_valid_r;
  logic [LANES*WI-1:0]        s1_data_r;
  logic [LANES*WI-1:0]        act_s;
  logic [LANES*DWIDTH_OUT-1:0] narrow_s;
  logic                       adv1_s;
  logic                       adv2_s;

  // Handshakes; reset suppresses both pops and pushes so no in-flight word escapes.
  always_comb begin
    adv2_s         = !s2_valid_r || !fifo_out_full;
    adv1_s         = !s1_valid_r || adv2_s;
    fifo_in_rd_en  = !reset && !fifo_in_empty && adv1_s;
    fifo_out_wr_en = !reset && s2_valid_r && !fifo_out_full;
    busy           = s1_valid_r || s2_valid_r;
  end

  // Per-lane activation of the word at the FIFO head, using the mode presented with it.
  always_comb begin
    act_s = '0;
    for (int i = 0; i < LANES; i++) begin
      act_s[i*WI +: WI] = act_f(fifo_in_dout[i*DWIDTH_IN +: DWIDTH_IN], mode);
    end
  end

  // Per-lane signed narrowing of stage-1 results.
  always_comb begin
    narrow_s = '0;
    for (int i = 0; i < LANES; i++) begin
      narrow_s[i*DWIDTH_OUT +: DWIDTH_OUT] = sat_val(s1_data_r[i*WI +: WI]);
    end
  end

  // Stage 1 register: activated lanes at full width plus one guard bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= fifo_in_rd_en;
      s1_data_r  <= act_s;
    end
  end

  // Stage 2 register drives the output FIFO data directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_r   <= 1'b0;
      fifo_out_din <= '0;
    end else if (adv2_s) begin
      s2_valid_r   <= s1_valid_r;
      fifo_out_din <= narrow_s;
    end
  end

`ifdef ACTIVATION_STREAM_STATS_EN
  logic             s1_neg_r;
  logic             s2_neg_r;
  logic [LANES-1:0] s2_sat_r;
  logic             neg_s;
  logic [LANES-1:0] sat_s;

  // Per-word negative-input flag and per-lane clamp flags.
  always_comb begin
    neg_s = 1'b0;
    sat_s = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_s    = neg_s | fifo_in_dout[i*DWIDTH_IN + DWIDTH_IN - 1];
      sat_s[i] = ($signed(s1_data_r[i*WI +: WI]) > OUT_MAX) ||
                 ($signed(s1_data_r[i*WI +: WI]) < OUT_MIN);
    end
  end

  // Flags travel with their word through both stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_neg_r <= 1'b0;
      s2_neg_r <= 1'b0;
      s2_sat_r <= '0;
    end else begin
      if (adv1_s) begin
        s1_neg_r <= neg_s;
      end
      if (adv2_s) begin
        s2_neg_r <= s1_neg_r;
        s2_sat_r <= sat_s;
      end
    end
  end

  // Counters step only on an actual push, so stalls leave them unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_count <= 32'd0;
      sat_count  <= 32'd0;
      neg_count  <= 32'd0;
    end else if (fifo_out_wr_en) begin
      word_count <= word_count + 32'd1;
      if (|s2_sat_r) begin
        sat_count <= sat_count + 32'd1;
      end
      if (s2_neg_r) begin
        neg_count <= neg_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_activation_stream.sv
// Self-checking bench for activation_stream: FIFO models, arithmetic reference model and scoreboard.
module tb_activation_stream;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  mode;
  } word_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        fifo_in_rd_en;
  logic [31:0] fifo_in_dout = 32'd0;
  logic        fifo_in_empty = 1'b1;
  logic        fifo_out_wr_en;
  logic [15:0] fifo_out_din;
  logic        fifo_out_full = 1'b0;
  logic        busy;
`ifdef ACTIVATION_STREAM_STATS_EN
  logic [31:0] word_count;
  logic [31:0] sat_count;
  logic [31:0] neg_count;
`endif

  word_t       inq[$];
  logic [15:0] expq[$];
  int          checks = 0;
  int          errors = 0;
  int          total_writes = 0;
  logic        last_wr;
  logic [15:0] last_din;

  activation_stream dut (
    .clock(clock), .reset(reset), .mode(mode),
    .fifo_in_rd_en(fifo_in_rd_en), .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
    .fifo_out_wr_en(fifo_out_wr_en), .fifo_out_din(fifo_out_din), .fifo_out_full(fifo_out_full),
    .busy(busy)
`ifdef ACTIVATION_STREAM_STATS_EN
    , .word_count(word_count), .sat_count(sat_count), .neg_count(neg_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic int model_lane(input int x, input logic [1:0] m);
    int y;
    case (m)
      2'b00:   y = x;
      2'b01:   y = (x < 0) ? 0 : x;
      2'b10:   y = (x < 0) ? -((-x + 7) / 8) : x;
      default: y = (x < 0) ? 0 : ((x > 96) ? 96 : x);
    endcase
    if (y > 127) y = 127;
    else if (y < -128) y = -128;
    return y;
  endfunction

  function automatic logic [15:0] model_word(input word_t w);
    int a;
    int b;
    logic [7:0] ra;
    logic [7:0] rb;
    a  = int'($signed(w.data[15:0]));
    b  = int'($signed(w.data[31:16]));
    ra = 8'(model_lane(a, w.mode));
    rb = 8'(model_lane(b, w.mode));
    return {rb, ra};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_in();
    if (inq.size() > 0) begin
      fifo_in_empty = 1'b0;
      fifo_in_dout  = inq[0].data;
      mode          = inq[0].mode;
    end else begin
      fifo_in_empty = 1'b1;
      fifo_in_dout  = 32'd0;
      mode          = 2'b00;
    end
  endtask

  task automatic step();
    int    occ;
    logic  rd;
    logic  wr;
    word_t w;
    @(negedge clock);
    rd  = fifo_in_rd_en;
    wr  = fifo_out_wr_en;
    occ = expq.size();
    if (reset) begin
      check("rd_in_reset", rd, 0);
      check("wr_in_reset", wr, 0);
    end else begin
      check("busy", busy, occ != 0);
      check("rd_en", rd, (!fifo_in_empty && (occ < 2 || !fifo_out_full)));
      if (wr) begin
        check("wr_when_full", fifo_out_full, 0);
        if (expq.size() == 0) check("spurious_write", wr, 0);
        else check("out_word", fifo_out_din, expq.pop_front());
        total_writes++;
      end
    end
    last_wr  = wr;
    last_din = fifo_out_din;
    @(posedge clock);
    #1;
    if (rd) begin
      w = inq.pop_front();
      expq.push_back(model_word(w));
    end
    drive_in();
  endtask

  task automatic push(input logic [15:0] x0, input logic [15:0] x1, input logic [1:0] m);
    word_t w;
    w.data = {x1, x0};
    w.mode = m;
    inq.push_back(w);
    drive_in();
  endtask

  task automatic run_single(input string name, input logic [15:0] x0, input logic [15:0] x1,
                            input logic [1:0] m, input logic [15:0] lit);
    push(x0, x1, m);
    step(); step(); step();
    check({name, "_wr"}, last_wr, 1);
    check(name, last_din, lit);
    step();
  endtask

  initial begin
    int bp_start;
    int n;
    drive_in();
    step(); step();
    reset = 1'b0;
    step();
    check("reset_din", last_din, 16'h0000);
    check("reset_wr", last_wr, 0);
    check("reset_busy", busy, 0);
`ifdef ACTIVATION_STREAM_STATS_EN
    check("reset_word_count", word_count, 32'd0);
`endif

    run_single("pass_sat", 16'd300, -16'sd300, 2'b00, 16'h807F);
`ifdef ACTIVATION_STREAM_STATS_EN
    check("sat_count", sat_count, 32'd1);
    check("neg_count", neg_count, 32'd1);
    check("word_count", word_count, 32'd1);
`endif
    run_single("relu", -16'sd5, 16'd40, 2'b01, 16'h2800);
    run_single("leaky", -16'sd20, -16'sd1, 2'b10, 16'hFFFD);
    run_single("clip", 16'd200, 16'd50, 2'b11, 16'h3260);

    push(-16'sd7, 16'd120, 2'b01);
    push(-16'sd7, 16'd120, 2'b11);
    step(); step(); step();
    check("toggle_first", last_din, 16'h7800);
    step();
    check("toggle_second_wr", last_wr, 1);
    check("toggle_second", last_din, 16'h6000);
    step();

    bp_start = total_writes;
    for (int i = 1; i <= 8; i++) push(16'(i), 16'(i), 2'b00);
    step(); step(); step();
    fifo_out_full = 1'b1;
    for (int i = 0; i < 5; i++) step();
    fifo_out_full = 1'b0;
    n = 0;
    while ((inq.size() != 0 || expq.size() != 0) && n < 40) begin
      step();
      n++;
    end
    check("bp_drain", expq.size(), 0);
    check("bp_writes", total_writes - bp_start, 8);

    push(16'd11, 16'd11, 2'b00);
    push(16'd12, 16'd12, 2'b00);
    step(); step();
    reset = 1'b1;
    inq.delete();
    expq.delete();
    drive_in();
    step();
    reset = 1'b0;
    step();
    check("rst_mid_wr", last_wr, 0);
    check("rst_mid_din", last_din, 16'h0000);
    check("rst_mid_busy", busy, 0);
    run_single("after_reset", 16'd5, 16'd6, 2'b00, 16'h0605);

    for (int i = 0; i < 10; i++) step();
    check("idle_rd", fifo_in_rd_en, 0);
    check("idle_wr", fifo_out_wr_en, 0);
    check("idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
